// File: rtl/memory_stage.sv
// memory_stage: EX/MEM register, fixed-latency word data memory and MEM/WB register.
// Optional load/store access counters are compiled in when MEM_STATS_EN is defined.
module memory_stage #(
   parameter int DATA      = 32,
   parameter int REG_WIDTH = 5,
   parameter int MEM_WORDS = 1024,
   parameter int MEM_LAT   = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 ex_valid,
   input  logic [DATA-1:0]      alu_o,
   input  logic [DATA-1:0]      wr_data,
   input  logic [REG_WIDTH-1:0] exec_read,
   input  logic                 is_taken,
   input  logic [DATA-1:0]      addr_new,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic                 reg_write,
   input  logic                 halt,
   output logic                 mem_stall,
   output logic                 redirect,
   output logic [DATA-1:0]      redirect_pc,
   output logic                 wb_valid,
   output logic                 wb_we,
   output logic [REG_WIDTH-1:0] wb_reg,
   output logic [DATA-1:0]      wb_data,
   output logic                 mem_fault,
   output logic                 halted,
   output logic [31:0]          load_count,
   output logic [31:0]          store_count
);

   localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;

   logic [IDX_W-1:0]     r_idx;
   logic [DATA-1:0]      r_wdata;
   logic [REG_WIDTH-1:0] r_dest;
   logic                 r_is_load;
   logic                 r_reg_we;
   logic                 r_halt;

   logic                 r_wb_valid;
   logic                 r_wb_we;
   logic [REG_WIDTH-1:0] r_wb_reg;
   logic [DATA-1:0]      r_wb_data;
   logic                 r_redirect;
   logic [DATA-1:0]      r_redirect_pc;
   logic                 r_mem_fault;
   logic                 r_halted;

   logic [DATA-1:0]      r_mem [MEM_WORDS];

   logic                 w_capture;
   logic                 w_is_mem;
   logic                 w_misalign;
   logic                 w_start;
   logic                 w_done;
   logic                 w_store_en;
   logic [DATA-1:0]      w_rd_data;

   assign w_capture  = ex_valid && (r_state == S_IDLE) && !r_halted;
   assign w_is_mem   = mem_read || mem_write;
   assign w_misalign = (alu_o[1:0] != 2'b00);
   assign w_start    = w_capture && w_is_mem && !w_misalign;
   assign w_done     = (r_state == S_BUSY) && (r_cnt == '0);
   // A combined read+write is treated as a load, so only pure stores write memory.
   assign w_store_en = w_done && !r_is_load;
   assign w_rd_data  = r_mem[r_idx];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_start) w_state_nxt = S_BUSY;
         S_BUSY: if (r_cnt == '0) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // EX/MEM register: holds the in-flight access while the stage is busy.
   always_ff @(posedge clock) begin
      if (w_start) begin
         r_idx     <= alu_o[IDX_W+1:2];
         r_wdata   <= wr_data;
         r_dest    <= exec_read;
         r_is_load <= mem_read;
         r_reg_we  <= reg_write;
         r_halt    <= halt;
      end
   end

   always_ff @(posedge clock) begin
      if (w_store_en) begin
         r_mem[r_idx] <= r_wdata;
      end
   end

   // MEM/WB register, redirect and sticky status.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt         <= '0;
         r_wb_valid    <= 1'b0;
         r_wb_we       <= 1'b0;
         r_wb_reg      <= '0;
         r_wb_data     <= '0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
         r_mem_fault   <= 1'b0;
         r_halted      <= 1'b0;
      end else begin
         r_wb_valid <= 1'b0;
         r_redirect <= 1'b0;
         if (w_capture) begin
            if (is_taken) begin
               r_redirect    <= 1'b1;
               r_redirect_pc <= addr_new;
            end
            if (!w_is_mem) begin
               r_wb_valid <= 1'b1;
               r_wb_we    <= reg_write;
               r_wb_reg   <= exec_read;
               r_wb_data  <= alu_o;
               if (halt) r_halted <= 1'b1;
            end else if (w_misalign) begin
               r_wb_valid  <= 1'b1;
               r_wb_we     <= 1'b0;
               r_wb_reg    <= exec_read;
               r_wb_data   <= alu_o;
               r_mem_fault <= 1'b1;
               if (halt) r_halted <= 1'b1;
            end else begin
               r_cnt <= CNT_W'(MEM_LAT - 1);
            end
         end
         if (r_state == S_BUSY) begin
            if (r_cnt != '0) begin
               r_cnt <= r_cnt - 1'b1;
            end else begin
               r_wb_valid <= 1'b1;
               r_wb_we    <= r_is_load ? r_reg_we : 1'b0;
               r_wb_reg   <= r_dest;
               if (r_is_load) r_wb_data <= w_rd_data;
               if (r_halt) r_halted <= 1'b1;
            end
         end
      end
   end

   assign mem_stall   = (r_state == S_BUSY);
   assign redirect    = r_redirect;
   assign redirect_pc = r_redirect_pc;
   assign wb_valid    = r_wb_valid;
   assign wb_we       = r_wb_we;
   assign wb_reg      = r_wb_reg;
   assign wb_data     = r_wb_data;
   assign mem_fault   = r_mem_fault;
   assign halted      = r_halted;

`ifdef MEM_STATS_EN
   logic [31:0] r_load_cnt;
   logic [31:0] r_store_cnt;
   logic        w_load_done;

   assign w_load_done = w_done && r_is_load;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_load_cnt  <= '0;
         r_store_cnt <= '0;
      end else begin
         if (w_load_done && (r_load_cnt != 32'hFFFF_FFFF)) r_load_cnt <= r_load_cnt + 32'd1;
         if (w_store_en && (r_store_cnt != 32'hFFFF_FFFF)) r_store_cnt <= r_store_cnt + 32'd1;
      end
   end

   assign load_count  = r_load_cnt;
   assign store_count = r_store_cnt;
`else
   assign load_count  = '0;
   assign store_count = '0;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: directed vector table, reset/stats/halt sequences,
// and randomized traffic against a transaction-level reference model.
module tb_memory_stage;

   localparam int DATA      = 32;
   localparam int REG_WIDTH = 5;
   localparam int MEM_WORDS = 1024;
   localparam int MEM_LAT   = 2;
`ifdef MEM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        ex_valid = 1'b0;
   logic [31:0] alu_o = '0;
   logic [31:0] wr_data = '0;
   logic [4:0]  exec_read = '0;
   logic        is_taken = 1'b0;
   logic [31:0] addr_new = '0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic        reg_write = 1'b0;
   logic        halt = 1'b0;

   logic        mem_stall, redirect, wb_valid, wb_we, mem_fault, halted;
   logic [31:0] redirect_pc, wb_data, load_count, store_count;
   logic [4:0]  wb_reg;

   memory_stage #(.DATA(DATA), .REG_WIDTH(REG_WIDTH), .MEM_WORDS(MEM_WORDS), .MEM_LAT(MEM_LAT)) dut (
      .clock(clock), .reset(reset), .ex_valid(ex_valid), .alu_o(alu_o), .wr_data(wr_data),
      .exec_read(exec_read), .is_taken(is_taken), .addr_new(addr_new), .mem_read(mem_read),
      .mem_write(mem_write), .reg_write(reg_write), .halt(halt), .mem_stall(mem_stall),
      .redirect(redirect), .redirect_pc(redirect_pc), .wb_valid(wb_valid), .wb_we(wb_we),
      .wb_reg(wb_reg), .wb_data(wb_data), .mem_fault(mem_fault), .halted(halted),
      .load_count(load_count), .store_count(store_count)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one pending access plus a countdown of remaining stall cycles.
   logic [31:0] mdl_mem [MEM_WORDS];
   int          m_left;
   logic        m_p_load, m_p_we, m_p_halt;
   int          m_p_idx;
   logic [31:0] m_p_wdata;
   logic [4:0]  m_p_dest;
   logic        e_wb_valid, e_we, e_chk_rd, e_redirect, e_fault, e_halted;
   logic [4:0]  e_reg;
   logic [31:0] e_data, e_pc, e_loads, e_stores;

   task automatic model_reset();
      m_left = 0;
      e_wb_valid = 0; e_we = 0; e_chk_rd = 0; e_redirect = 0; e_fault = 0; e_halted = 0;
      e_reg = 0; e_data = 0; e_pc = 0; e_loads = 0; e_stores = 0;
   endtask

   task automatic model_step();
      e_wb_valid = 0; e_redirect = 0; e_chk_rd = 0;
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            e_wb_valid = 1;
            if (m_p_load) begin
               e_we = m_p_we; e_reg = m_p_dest; e_data = mdl_mem[m_p_idx]; e_chk_rd = 1;
               if (e_loads != 32'hFFFF_FFFF) e_loads++;
            end else begin
               e_we = 0;
               mdl_mem[m_p_idx] = m_p_wdata;
               if (e_stores != 32'hFFFF_FFFF) e_stores++;
            end
            if (m_p_halt) e_halted = 1;
         end
      end else if (ex_valid && !e_halted) begin
         if (is_taken) begin e_redirect = 1; e_pc = addr_new; end
         if (!(mem_read || mem_write)) begin
            e_wb_valid = 1; e_we = reg_write; e_reg = exec_read; e_data = alu_o; e_chk_rd = 1;
            if (halt) e_halted = 1;
         end else if (alu_o % 4 != 0) begin
            e_wb_valid = 1; e_we = 0; e_fault = 1;
            if (halt) e_halted = 1;
         end else begin
            m_left = MEM_LAT;
            m_p_load = mem_read; m_p_we = reg_write; m_p_halt = halt;
            m_p_idx = int'((alu_o / 4) % MEM_WORDS);
            m_p_wdata = wr_data; m_p_dest = exec_read;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
      check("wb_valid", 32'(wb_valid), 32'(e_wb_valid));
      check("mem_stall", 32'(mem_stall), 32'(m_left > 0));
      check("redirect", 32'(redirect), 32'(e_redirect));
      if (e_redirect) check("redirect_pc", redirect_pc, e_pc);
      if (e_wb_valid) check("wb_we", 32'(wb_we), 32'(e_we));
      if (e_chk_rd) begin
         check("wb_reg", 32'(wb_reg), 32'(e_reg));
         check("wb_data", wb_data, e_data);
      end
      check("mem_fault", 32'(mem_fault), 32'(e_fault));
      check("halted", 32'(halted), 32'(e_halted));
      check("load_count", load_count, STATS ? e_loads : 32'd0);
      check("store_count", store_count, STATS ? e_stores : 32'd0);
   endtask

   task automatic clear_inputs();
      ex_valid = 0; is_taken = 0; halt = 0; mem_read = 0; mem_write = 0; reg_write = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      #2 reset = 1'b1;
      #1;
      model_reset();
      check("rst_mem_stall", 32'(mem_stall), 32'd0);
      check("rst_redirect", 32'(redirect), 32'd0);
      check("rst_redirect_pc", redirect_pc, 32'd0);
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_wb_we", 32'(wb_we), 32'd0);
      check("rst_wb_reg", 32'(wb_reg), 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      check("rst_mem_fault", 32'(mem_fault), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_load_count", load_count, 32'd0);
      check("rst_store_count", store_count, 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   typedef struct {
      logic [31:0] alu, wdata, target;
      logic [4:0]  rd;
      logic        rdn, wr, we, taken, hlt;
      int          exp_lat;
      logic        exp_we;
      logic [4:0]  exp_reg;
      logic [31:0] exp_data;
      logic        chk_data, exp_fault;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] alu, wdata, target, input logic [4:0] rd,
                               input logic rdn, wr, we, taken, hlt, input int lat,
                               input logic xwe, input logic [4:0] xreg, input logic [31:0] xdata,
                               input logic chk, xfault);
      vec_t v;
      v.alu = alu; v.wdata = wdata; v.target = target; v.rd = rd;
      v.rdn = rdn; v.wr = wr; v.we = we; v.taken = taken; v.hlt = hlt;
      v.exp_lat = lat; v.exp_we = xwe; v.exp_reg = xreg; v.exp_data = xdata;
      v.chk_data = chk; v.exp_fault = xfault;
      return v;
   endfunction

   int          g_lat;
   logic        g_red, g_we, g_fault;
   logic [31:0] g_pc, g_data;
   logic [4:0]  g_reg;

   task automatic issue(input vec_t v);
      int guard = 0;
      while (mem_stall && guard < 20) begin tick(); guard++; end
      alu_o = v.alu; wr_data = v.wdata; addr_new = v.target; exec_read = v.rd;
      mem_read = v.rdn; mem_write = v.wr; reg_write = v.we; is_taken = v.taken; halt = v.hlt;
      ex_valid = 1;
      tick();
      g_lat = 1; g_red = redirect; g_pc = redirect_pc;
      clear_inputs();
      while (!wb_valid && g_lat < 20) begin tick(); g_lat++; end
      g_we = wb_we; g_reg = wb_reg; g_data = wb_data; g_fault = mem_fault;
   endtask

   vec_t vecs[$];
   localparam int ML = MEM_LAT + 1;

   initial begin
      model_reset();
      do_reset();

      vecs.push_back(mk(32'h15, 0, 0, 3, 0, 0, 1, 0, 0, 1, 1, 3, 32'h15, 1, 0));
      vecs.push_back(mk(32'h40, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 0, ML, 0, 0, 0, 0, 0));
      vecs.push_back(mk(32'h40, 0, 0, 7, 1, 0, 1, 0, 0, ML, 1, 7, 32'hDEADBEEF, 1, 0));
      vecs.push_back(mk(32'h42, 0, 0, 5, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(32'h0, 0, 32'h100, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(32'h40, 32'h1111, 0, 9, 1, 1, 1, 0, 0, ML, 1, 9, 32'hDEADBEEF, 1, 1));
      vecs.push_back(mk(32'h40, 0, 0, 10, 1, 0, 1, 0, 0, ML, 1, 10, 32'hDEADBEEF, 1, 1));
      vecs.push_back(mk(32'(MEM_WORDS * 4 + 'h44), 32'h12345678, 0, 0, 0, 1, 0, 0, 0, ML, 0, 0, 0, 0, 1));
      vecs.push_back(mk(32'h44, 0, 0, 11, 1, 0, 1, 0, 0, ML, 1, 11, 32'h12345678, 1, 1));
      vecs.push_back(mk(32'h40, 0, 32'h200, 12, 1, 0, 1, 1, 0, ML, 1, 12, 32'hDEADBEEF, 1, 1));

      foreach (vecs[i]) begin
         issue(vecs[i]);
         check($sformatf("vec%0d_latency", i), 32'(g_lat), 32'(vecs[i].exp_lat));
         check($sformatf("vec%0d_redirect", i), 32'(g_red), 32'(vecs[i].taken));
         if (vecs[i].taken) check($sformatf("vec%0d_redirect_pc", i), g_pc, vecs[i].target);
         check($sformatf("vec%0d_wb_we", i), 32'(g_we), 32'(vecs[i].exp_we));
         if (vecs[i].chk_data) begin
            check($sformatf("vec%0d_wb_reg", i), 32'(g_reg), 32'(vecs[i].exp_reg));
            check($sformatf("vec%0d_wb_data", i), g_data, vecs[i].exp_data);
         end
         check($sformatf("vec%0d_mem_fault", i), 32'(g_fault), 32'(vecs[i].exp_fault));
      end

      // Reset in the middle of a store must leave the old word in place.
      issue(mk(32'h80, 32'hAAAA5555, 0, 0, 0, 1, 0, 0, 0, ML, 0, 0, 0, 0, 0));
      alu_o = 32'h80; wr_data = 32'h0BAD0BAD; mem_write = 1; ex_valid = 1;
      tick();
      clear_inputs();
      tick();
      do_reset();
      for (int k = 0; k < 3; k++) tick();
      issue(mk(32'h80, 0, 0, 4, 1, 0, 1, 0, 0, ML, 1, 4, 32'hAAAA5555, 1, 0));
      check("rst_busy_load_data", g_data, 32'hAAAA5555);
      check("rst_busy_load_latency", 32'(g_lat), 32'(ML));

      // Preload the random address window, then random traffic with ex_valid held during stalls.
      for (int k = 0; k < 16; k++)
         issue(mk(32'((48 + k) * 4), $urandom(), 0, 0, 0, 1, 0, 0, 0, ML, 0, 0, 0, 0, 0));
      for (int c = 0; c < 600; c++) begin
         int kind;
         logic [31:0] base;
         kind = $urandom_range(0, 9);
         base = ($urandom() & ~32'(MEM_WORDS * 4 - 1)) | 32'((48 + $urandom_range(0, 15)) * 4);
         ex_valid = ($urandom_range(0, 1) == 1);
         is_taken = ($urandom_range(0, 3) == 0);
         addr_new = $urandom();
         exec_read = 5'($urandom_range(0, 31));
         reg_write = ($urandom_range(0, 3) != 0);
         wr_data = $urandom();
         halt = 0;
         mem_read = (kind >= 3 && kind <= 5) || kind == 8 || (kind == 9 && base[4]);
         mem_write = (kind == 6 || kind == 7 || kind == 8 || (kind == 9 && !base[4]));
         alu_o = (kind <= 2) ? $urandom() : (kind == 9 ? base + 32'($urandom_range(1, 3)) : base);
         tick();
      end
      clear_inputs();
      for (int k = 0; k < 4; k++) tick();

      // Counter and halt sequence from a clean reset.
      do_reset();
      for (int k = 0; k < 3; k++)
         issue(mk(32'(32'h100 + k * 4), 32'(32'hC0DE0000 + k), 0, 0, 0, 1, 0, 0, 0, ML, 0, 0, 0, 0, 0));
      issue(mk(32'h100, 0, 0, 1, 1, 0, 1, 0, 0, ML, 1, 1, 32'hC0DE0000, 1, 0));
      check("stats_load0_data", g_data, 32'hC0DE0000);
      issue(mk(32'h108, 0, 0, 2, 1, 0, 1, 0, 0, ML, 1, 2, 32'hC0DE0002, 1, 0));
      check("stats_load1_data", g_data, 32'hC0DE0002);
      issue(mk(32'h101, 32'h5, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1));
      check("stats_store_count", store_count, STATS ? 32'd3 : 32'd0);
      check("stats_load_count", load_count, STATS ? 32'd2 : 32'd0);
      check("stats_fault", 32'(mem_fault), 32'd1);

      issue(mk(32'h7, 0, 0, 6, 0, 0, 1, 0, 1, 1, 1, 6, 32'h7, 1, 1));
      check("halt_set", 32'(halted), 32'd1);
      begin
         int pulses = 0;
         alu_o = 32'h99; exec_read = 8; reg_write = 1; ex_valid = 1;
         for (int k = 0; k < 5; k++) begin
            tick();
            if (wb_valid) pulses++;
         end
         clear_inputs();
         check("halt_ignores_ex_valid", 32'(pulses), 32'd0);
      end
      check("halt_sticky", 32'(halted), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
